// File: rtl/base_rrmux_if.sv
// base_rrmux_if: bundles the per-way input streams and the merged output stream.
//   i_v/i_r/i_d : per-way valid, ready and packed data (way w at [w*width +: width])
//   o_v/o_r/o_d : merged output valid, downstream ready and data
//   o_s         : one-hot source way of the current output beat
// Modports: master = stream sources plus downstream sink, slave = the merge stage.
interface base_rrmux_if #(
  parameter int unsigned ways  = 2,
  parameter int unsigned width = 8
);
  logic [0:ways-1]       i_v;
  logic [0:ways-1]       i_r;
  logic [0:ways*width-1] i_d;
  logic                  o_v;
  logic                  o_r;
  logic [0:width-1]      o_d;
  logic [0:ways-1]       o_s;

  modport master (
    output i_v, i_d, o_r,
    input  i_r, o_v, o_d, o_s
  );

  modport slave (
    input  i_v, i_d, o_r,
    output i_r, o_v, o_d, o_s
  );
endinterface

// File: rtl/base_rrmux.sv
// base_rrmux: registered round-robin merge of `ways` valid/ready streams.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : base_rrmux_if.slave (i_v/i_r/i_d in, o_v/o_r/o_d/o_s out)
// The winner's data lands in a single output register with a one-hot source tag;
// priority rotates to start just after the most recently granted way.
module base_rrmux #(
  parameter int unsigned ways  = 2,
  parameter int unsigned width = 8
) (
  input  logic         clk,
  input  logic         reset,
  base_rrmux_if.slave  bus
);

  localparam int unsigned IDX_W = (ways > 1) ? $clog2(ways) : 1;
  // Way ways-1 marked as last so way 0 wins first after reset.
  localparam logic [0:ways-1] LAST_RST = {{(ways-1){1'b0}}, 1'b1};

  logic [0:ways-1]  last_q, last_d;
  logic             o_v_q, o_v_d;
  logic [0:width-1] o_d_q, o_d_d;
  logic [0:ways-1]  o_s_q, o_s_d;

  logic [0:ways-1]  gnt;
  logic             found;
  logic             ld;

  // Register may load when empty or draining this cycle.
  assign ld = ~o_v_q | bus.o_r;

  // Rotating-priority search: offset k from the last-granted way j.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= ways; k++) begin
      for (int unsigned j = 0; j < ways; j++) begin
        if (!found && last_q[j] && bus.i_v[IDX_W'((j + k) % ways)]) begin
          gnt[IDX_W'((j + k) % ways)] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  // No acceptance while reset is held, so nothing is lost in the reset cycle.
  assign bus.i_r = gnt & {ways{ld & ~reset}};

  // Next-state: load the granted beat, drain when empty-going, otherwise hold.
  always_comb begin
    o_v_d  = o_v_q;
    o_d_d  = o_d_q;
    o_s_d  = o_s_q;
    last_d = last_q;
    if (ld && found) begin
      o_v_d  = 1'b1;
      o_s_d  = gnt;
      last_d = gnt;
      for (int unsigned w = 0; w < ways; w++) begin
        if (gnt[w]) begin
          o_d_d = bus.i_d[w*width +: width];
        end
      end
    end else if (ld) begin
      o_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_v_q  <= 1'b0;
      o_d_q  <= '0;
      o_s_q  <= '0;
      last_q <= LAST_RST;
    end else begin
      o_v_q  <= o_v_d;
      o_d_q  <= o_d_d;
      o_s_q  <= o_s_d;
      last_q <= last_d;
    end
  end

  assign bus.o_v = o_v_q;
  assign bus.o_d = o_d_q;
  assign bus.o_s = o_s_q;

endmodule

// File: tb/tb_base_rrmux.sv
// tb_base_rrmux: directed and randomized checks of base_rrmux (ways=4, width=8)
// against an integer-index reference model and a beat scoreboard.
module tb_base_rrmux;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [0:WAYS-1]  s;
  } beat_t;

  logic clk;
  logic reset;

  base_rrmux_if #(.ways(WAYS), .width(WIDTH)) bus ();

  base_rrmux #(.ways(WAYS), .width(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Stimulus state
  logic [WIDTH-1:0] dat [WAYS];

  // Reference model state
  logic             m_ov;
  logic [WIDTH-1:0] m_od;
  logic [0:WAYS-1]  m_os;
  int               m_last;

  // Scoreboard and fairness tracking
  beat_t sb [$];
  int    waitc [WAYS];

  // Samples taken before the edge
  logic [0:WAYS-1]  s_ir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:WAYS-1] onehot(input int w);
    logic [0:WAYS-1] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic drive_data();
    for (int w = 0; w < WAYS; w++) bus.i_d[w*WIDTH +: WIDTH] = dat[w];
  endtask

  task automatic model_reset();
    m_ov   = 1'b0;
    m_od   = '0;
    m_os   = '0;
    m_last = WAYS - 1;
    sb.delete();
    for (int w = 0; w < WAYS; w++) waitc[w] = 0;
  endtask

  // One clock: check before the edge, advance model after it.
  task automatic cycle();
    logic            ld;
    int              g;
    logic [0:WAYS-1] exp_ir;
    logic [0:WAYS-1] iv;
    logic            orr;
    logic [WIDTH-1:0] obs_d;
    logic [0:WAYS-1]  obs_s;
    logic             obs_v;
    beat_t            b;
    drive_data();
    @(negedge clk);
    iv  = bus.i_v;
    orr = bus.o_r;
    ld  = !m_ov || orr;
    g   = -1;
    if (!reset) begin
      for (int k = 1; k <= WAYS; k++) begin
        if (g < 0 && iv[(m_last + k) % WAYS]) g = (m_last + k) % WAYS;
      end
    end
    exp_ir = (ld && g >= 0) ? onehot(g) : '0;
    s_ir   = bus.i_r;
    obs_v  = bus.o_v;
    obs_d  = bus.o_d;
    obs_s  = bus.o_s;
    chk("i_r", 32'(s_ir), 32'(exp_ir));
    chk("o_v", 32'(obs_v), 32'(m_ov));
    chk("o_d", 32'(obs_d), 32'(m_od));
    chk("o_s", 32'(obs_s), 32'(m_os));

    if (reset) begin
      model_reset();
    end else begin
      // Output beat consumed: must be the oldest accepted one.
      if (obs_v && orr) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(1), 32'(0));
        end else begin
          b = sb.pop_front();
          chk("sb_data", 32'(obs_d), 32'(b.d));
          chk("sb_src", 32'(obs_s), 32'(b.s));
        end
      end
      for (int w = 0; w < WAYS; w++) begin
        if (s_ir[w]) begin
          b.d = dat[w];
          b.s = onehot(w);
          sb.push_back(b);
        end
      end
      // Fairness: count accepted beats taken by others while a way waits.
      for (int w = 0; w < WAYS; w++) begin
        if (!iv[w] || s_ir[w]) begin
          waitc[w] = 0;
        end else if (|s_ir) begin
          waitc[w]++;
          chk("starve", 32'(waitc[w] < WAYS), 32'(1));
        end
      end
      if (ld && g >= 0) begin
        m_ov   = 1'b1;
        m_od   = dat[g];
        m_os   = onehot(g);
        m_last = g;
      end else if (ld) begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] rr_d [5];
  logic [0:WAYS-1]  rr_s [5];

  initial begin
    tests = 0;
    fails = 0;
    rr_d[0] = 8'h10; rr_d[1] = 8'h11; rr_d[2] = 8'h12; rr_d[3] = 8'h13; rr_d[4] = 8'h10;
    rr_s[0] = 4'b1000; rr_s[1] = 4'b0100; rr_s[2] = 4'b0010; rr_s[3] = 4'b0001; rr_s[4] = 4'b1000;
    for (int w = 0; w < WAYS; w++) dat[w] = WIDTH'(8'h10 + w);

    // Reset with all ways requesting and sink ready
    reset   = 1'b1;
    bus.i_v = '1;
    bus.o_r = 1'b1;
    drive_data();
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_ir", 32'(s_ir), 32'(0));
      chk("rst_ov", 32'(bus.o_v), 32'(0));
      chk("rst_od", 32'(bus.o_d), 32'(0));
      chk("rst_os", 32'(bus.o_s), 32'(0));
    end
    reset = 1'b0;

    // Round-robin with all ways valid
    cycle();
    chk("first_ir", 32'(s_ir), 32'(4'b1000));
    for (int i = 0; i < 5; i++) begin
      chk("rr_od", 32'(bus.o_d), 32'(rr_d[i]));
      chk("rr_os", 32'(bus.o_s), 32'(rr_s[i]));
      cycle();
    end

    // Backpressure on a way-2 beat
    bus.i_v = 4'b0010;
    dat[2]  = 8'hA5;
    cycle();
    bus.o_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ir", 32'(s_ir), 32'(0));
      chk("bp_ov", 32'(bus.o_v), 32'(1));
      chk("bp_od", 32'(bus.o_d), 32'(8'hA5));
      chk("bp_os", 32'(bus.o_s), 32'(4'b0010));
    end
    bus.o_r = 1'b1;
    cycle();
    chk("bp_reaccept", 32'(s_ir), 32'(4'b0010));

    // Pointer hold across idle cycles
    bus.i_v = 4'b0100;
    cycle();
    chk("ph_gnt1", 32'(bus.o_s), 32'(4'b0100));
    bus.i_v = '0;
    for (int i = 0; i < 5; i++) cycle();
    chk("ph_idle_ov", 32'(bus.o_v), 32'(0));
    bus.i_v = 4'b0101;
    cycle();
    chk("ph_first3", 32'(bus.o_s), 32'(4'b0001));
    cycle();
    chk("ph_then1", 32'(bus.o_s), 32'(4'b0100));

    // Single requester
    bus.i_v = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("single_ir", 32'(s_ir), 32'(4'b1000));
      chk("single_os", 32'(bus.o_s), 32'(4'b1000));
    end

    // Reset during a stall discards the held beat
    dat[0]  = 8'h5C;
    cycle();
    bus.o_r = 1'b0;
    cycle();
    cycle();
    chk("ms_held", 32'(bus.o_d), 32'(8'h5C));
    reset = 1'b1;
    cycle();
    chk("ms_ov", 32'(bus.o_v), 32'(0));
    reset   = 1'b0;
    bus.i_v = '0;
    bus.o_r = 1'b1;
    cycle();
    chk("ms_gone", 32'(bus.o_v), 32'(0));

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      bus.i_v = 4'($urandom);
      bus.o_r = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < WAYS; w++) dat[w] = 8'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/base_rrmux.md
# base_rrmux

Registered round-robin merge stage for valid/ready streams: arbitrates among `ways` input streams, forwards the winner's data through a single output register, and reports which way won as a one-hot source tag. It is the merge counterpart of the base valid/ready demux. Response traffic fanned out by a demux is recombined here into one stream, and `o_s` carries the return-path select.

## Interface
Parameters:
- `ways`, 2: number of input streams (≥2).
- `width`, 8: data bits per stream.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `i_v`  in  [0:ways-1]: per-way valid.
- `i_r`  out  [0:ways-1]: per-way ready; a beat on way w transfers when `i_v[w] & i_r[w]`.
- `i_d`  in  [0:ways*width-1]: packed data; way w occupies bits [w*width : w*width+width-1].
- `o_v`  out  1: output valid (registered).
- `o_r`  in  1: output ready from downstream.
- `o_d`  out  [0:width-1]: output data (registered).
- `o_s`  out  [0:ways-1]: one-hot source way of the current output beat (registered).

## Operation
- **State**
  - Output register: `o_v`, `o_d`, `o_s`.
  - Round-robin pointer `last`, one-hot [0:ways-1], marking the most recently granted way.
- **Load enable.** `ld = ~o_v | o_r`. The register can accept a beat when it is empty or is draining this cycle.
- **Arbitration (combinational)**
  - Priority starts at the way after `last` and proceeds in increasing index order.
  - The search wraps from way ways-1 to way 0, so `last` itself has lowest priority.
  - `gnt` is a one-hot vector over `i_v`, or all-zero if there is no request.
- **Ready**
  - `i_r = gnt & {ways{ld}}`.
  - At most one `i_r` bit is high in any cycle.
  - `i_r` never depends on `i_d`.
  - `i_r[w]` may be high only when `i_v[w]` is high.
- **Transfer.** On a clock edge with `ld & |gnt`:
  - `o_v` ← 1.
  - `o_d` ← data of the granted way.
  - `o_s` ← `gnt`.
  - `last` ← `gnt`.
- **Drain.** On a clock edge with `o_v & o_r` and no new grant:
  - `o_v` ← 0.
  - `o_d` and `o_s` hold their values (don't-care while `o_v` is 0).
  - `last` holds.
- **Pointer.** `last` updates only on a granted transfer. Idle cycles and cycles stalled by `o_r`=0 leave it unchanged.
- **Stability.** While `o_v & ~o_r`, the values of `o_v`, `o_d` and `o_s` are held exactly.
- **Reset**
  - `o_v`=0, `o_d`=0, `o_s`=0.
  - `last` = one-hot way ways-1, so way 0 has first priority after reset.
  - A reset asserted mid-stall discards the held beat; no input beat is accepted in the reset cycle (`i_r` forced to 0 while `reset` is high).

## Timing
- **Latency.** 1 cycle: a beat accepted at edge N is presented on `o_d` after edge N.
- **Throughput.** One beat per cycle sustained when `o_r` is held high (back-to-back via `ld = o_r` while full).
- **Combinational paths**
  - `o_r` → `i_r` (through `ld`).
  - `i_v` → `i_r` (through arbitration).
  - No path from `i_v`/`i_d` to `o_v`, `o_d` or `o_s`.
- **Fairness.** With all ways continuously requesting and `o_r`=1, grants cycle 0,1,…,ways-1,0,…. Each way is served at least once every `ways` accepted beats.
- **Simultaneous drain and load.** `o_v` stays 1 and the register takes the new beat; no bubble is inserted.
- **Single requester.** A way that is the only requester is granted every cycle `ld` is high, regardless of `last`.

## Test plan
- **Reset.** Assert `reset` 2 cycles with all `i_v`=1 and `o_r`=1.
  - Required: `o_v`=0, `o_d`=0, `o_s`=0 and `i_r`=0 throughout.
  - First cycle after release: `i_r`=1 on way 0 only.
- **Round-robin** (ways=4, width=8). Hold all `i_v`=1 with way w data = 0x10+w, and hold `o_r`=1.
  - Required: `o_d` sequence 0x10, 0x11, 0x12, 0x13, 0x10 on consecutive cycles.
  - Required: `o_s` sequence 1000, 0100, 0010, 0001, 1000.
- **Backpressure.** Way 2 presents 0xA5 and `o_r` is held 0 for 3 cycles.
  - Required: `o_v`=1, `o_d`=0xA5, `o_s`=0010 stable across the stall.
  - Required: all `i_r`=0 during the stall.
  - Required: `o_r`=1 drains the beat; way 2 is accepted again the same cycle if it is still valid.
- **Pointer hold.** Grant way 1, go idle 5 cycles, then raise `i_v` on ways 1 and 3 together.
  - Required: way 3 is granted first, then way 1.
- **Single requester and reset mid-stall**
  - Only way 0 valid with `o_r`=1: way 0 is granted every cycle.
  - Stall with `o_v`=1, then assert `reset`: `o_v`=0 the next cycle and the held beat never appears.
- **Randomized throughput check.** Random `i_v`/`o_r` streams over 10k cycles.
  - Required: every accepted beat appears exactly once, in order per way, with the correct `o_s`.
  - Required: no way starves beyond `ways` accepted beats while requesting.
